// File: rtl/monster_wave_ctrl.sv
// Stage sequencer for the monster datapath: staggered spawning, kill counting,
// stage-clear detection and progression to WIN or LOSE.
module monster_wave_ctrl #(
  parameter int unsigned N_MON      = 4,
  parameter int unsigned SPAWN_GAP  = 64,
  parameter int unsigned CLEAR_HOLD = 128,
  parameter int unsigned LAST_STAGE = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               player_dead_i,
  input  logic [N_MON-1:0]   mon_dead_i,
  input  logic [4*N_MON-1:0] mon_state_i,
  output logic [3:0]         stage_o,
  output logic [4*N_MON-1:0] mon_stage_o,
  output logic [7:0]         kills_o,
  output logic               stage_clear_o,
  output logic               game_won_o,
  output logic               game_over_o
);

  localparam int unsigned IDX_W  = $clog2(N_MON + 1);
  localparam int unsigned GAP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int unsigned HOLD_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_FIGHT, S_CLEAR, S_WIN, S_LOSE
  } state_e;

  state_e              state_q;
  logic [3:0]          stage_q;
  logic [N_MON-1:0]    mask_q;
  logic [N_MON-1:0]    mon_dead_q;
  logic [IDX_W-1:0]    idx_q;
  logic [GAP_W-1:0]    gap_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [7:0]          kills_q;
  logic                stage_clear_q;
  logic                game_won_q;
  logic                game_over_q;

  logic [4:0]          active_n;
  logic                clear_ok;
  logic [N_MON-1:0]    rise;
  logic [N_MON-1:0]    spawn_bit;
  logic [3:0]          kill_inc;
  logic [8:0]          kill_sum;
  logic                fighting;

  // Stage-derived active count, clear detection, kill edges and spawn target bit.
  always_comb begin
    active_n = 5'(stage_q) + 5'd1;
    if (active_n > 5'(N_MON)) active_n = 5'(N_MON);
    clear_ok  = 1'b1;
    spawn_bit = '0;
    kill_inc  = '0;
    rise      = mon_dead_i & ~mon_dead_q & mask_q;
    for (int i = 0; i < N_MON; i++) begin
      if ((5'(i) < active_n) &&
          !(mon_dead_i[i] && (mon_state_i[4*i +: 4] == 4'hf))) begin
        clear_ok = 1'b0;
      end
      if (idx_q == IDX_W'(i)) spawn_bit[i] = 1'b1;
      kill_inc = kill_inc + 4'(rise[i]);
    end
    kill_sum = 9'(kills_q) + 9'(kill_inc);
    fighting = (state_q == S_SPAWN) || (state_q == S_FIGHT);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stage_q       <= 4'd0;
      mask_q        <= '0;
      mon_dead_q    <= '0;
      idx_q         <= '0;
      gap_q         <= '0;
      hold_q        <= '0;
      kills_q       <= 8'd0;
      stage_clear_q <= 1'b0;
      game_won_q    <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      mon_dead_q    <= mon_dead_i;
      stage_clear_q <= 1'b0;
      if (fighting && (kill_inc != 4'd0)) begin
        kills_q <= (kill_sum > 9'd255) ? 8'hff : kill_sum[7:0];
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SPAWN;
            stage_q <= 4'd1;
            kills_q <= 8'd0;
            mask_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
          end
        end
        S_SPAWN: begin
          if (player_dead_i) begin
            state_q     <= S_LOSE;
            stage_q     <= 4'hf;
            mask_q      <= '0;
            game_over_q <= 1'b1;
          end else if (gap_q == '0) begin
            mask_q <= mask_q | spawn_bit;
            idx_q  <= idx_q + IDX_W'(1);
            gap_q  <= GAP_W'(SPAWN_GAP - 1);
            if ((5'(idx_q) + 5'd1) >= active_n) state_q <= S_FIGHT;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        S_FIGHT: begin
          // Player death wins over a simultaneous clear.
          if (player_dead_i) begin
            state_q     <= S_LOSE;
            stage_q     <= 4'hf;
            mask_q      <= '0;
            game_over_q <= 1'b1;
          end else if (clear_ok) begin
            state_q       <= S_CLEAR;
            stage_clear_q <= 1'b1;
            mask_q        <= '0;
            hold_q        <= HOLD_W'(CLEAR_HOLD - 1);
          end
        end
        S_CLEAR: begin
          if (hold_q == '0) begin
            if (stage_q == 4'(LAST_STAGE)) begin
              state_q    <= S_WIN;
              stage_q    <= 4'hf;
              game_won_q <= 1'b1;
            end else begin
              state_q <= S_SPAWN;
              stage_q <= stage_q + 4'd1;
              mask_q  <= '0;
              idx_q   <= '0;
              gap_q   <= '0;
            end
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        S_WIN, S_LOSE: begin
          if (start_i) begin
            state_q     <= S_IDLE;
            stage_q     <= 4'd0;
            game_won_q  <= 1'b0;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Unspawned monsters are held home with stage 4'hf.
  always_comb begin
    for (int i = 0; i < N_MON; i++) begin
      mon_stage_o[4*i +: 4] = mask_q[i] ? stage_q : 4'hf;
    end
  end

  assign stage_o       = stage_q;
  assign kills_o       = kills_q;
  assign stage_clear_o = stage_clear_q;
  assign game_won_o    = game_won_q;
  assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_monster_wave_ctrl.sv
// Bench for monster_wave_ctrl: directed scenarios plus randomized play, checked
// every cycle against a time-based reference model of the game rules.
module tb_monster_wave_ctrl;

  localparam int unsigned N_MON      = 4;
  localparam int unsigned SPAWN_GAP  = 4;
  localparam int unsigned CLEAR_HOLD = 8;
  localparam int unsigned LAST_STAGE = 3;

  localparam int P_IDLE = 0, P_SPAWN = 1, P_FIGHT = 2, P_CLEAR = 3, P_WIN = 4, P_LOSE = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        player_dead;
  logic [3:0]  mon_dead;
  logic [15:0] mon_state;
  logic [3:0]  stage;
  logic [15:0] mon_stage;
  logic [7:0]  kills;
  logic        stage_clear;
  logic        game_won;
  logic        game_over;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  monster_wave_ctrl #(
    .N_MON(N_MON), .SPAWN_GAP(SPAWN_GAP), .CLEAR_HOLD(CLEAR_HOLD), .LAST_STAGE(LAST_STAGE)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .player_dead_i(player_dead),
    .mon_dead_i(mon_dead), .mon_state_i(mon_state),
    .stage_o(stage), .mon_stage_o(mon_stage), .kills_o(kills),
    .stage_clear_o(stage_clear), .game_won_o(game_won), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles spent in it; spawned monsters form a prefix.
  int         m_phase   = P_IDLE;
  int         m_stage   = 0;
  int         m_t       = 0;
  int         m_spawned = 0;
  int         m_kills   = 0;
  bit         m_clr     = 1'b0;
  bit         m_won     = 1'b0;
  bit         m_over    = 1'b0;
  logic [3:0] m_prev    = 4'd0;

  function automatic int act_n(input int s);
    return (s + 1 > int'(N_MON)) ? int'(N_MON) : s + 1;
  endfunction

  function automatic logic [15:0] exp_ms();
    logic [15:0] ms;
    for (int i = 0; i < 4; i++) ms[4*i +: 4] = (i < m_spawned) ? 4'(m_stage) : 4'hf;
    return ms;
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < act_n(m_stage); i++)
      if (!(mon_dead[i] && mon_state[4*i +: 4] == 4'hf)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] mask, rise;
    mask   = 4'((1 << m_spawned) - 1);
    rise   = mon_dead & ~m_prev & mask;
    m_prev = mon_dead;
    m_clr  = 1'b0;
    if (rst) begin
      m_phase = P_IDLE; m_stage = 0; m_t = 0; m_spawned = 0; m_kills = 0;
      m_won = 1'b0; m_over = 1'b0; m_prev = 4'd0;
    end else begin
      if (m_phase == P_SPAWN || m_phase == P_FIGHT) begin
        m_kills = m_kills + $countones(rise);
        if (m_kills > 255) m_kills = 255;
      end
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase = P_SPAWN; m_stage = 1; m_kills = 0; m_t = 0; m_spawned = 0;
        end
        P_SPAWN, P_FIGHT: begin
          if (player_dead) begin
            m_phase = P_LOSE; m_stage = 15; m_spawned = 0; m_over = 1'b1;
          end else if (m_phase == P_SPAWN) begin
            if (m_t % SPAWN_GAP == 0) m_spawned++;
            m_t++;
            if (m_spawned == act_n(m_stage)) m_phase = P_FIGHT;
          end else if (all_done()) begin
            m_phase = P_CLEAR; m_clr = 1'b1; m_spawned = 0; m_t = 0;
          end
        end
        P_CLEAR: begin
          if (m_t == int'(CLEAR_HOLD) - 1) begin
            if (m_stage == int'(LAST_STAGE)) begin
              m_phase = P_WIN; m_stage = 15; m_won = 1'b1;
            end else begin
              m_phase = P_SPAWN; m_stage++; m_t = 0; m_spawned = 0;
            end
          end else m_t++;
        end
        default: if (start) begin
          m_phase = P_IDLE; m_stage = 0; m_won = 1'b0; m_over = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stage", 32'(stage), 32'(m_stage));
      check("mon_stage", 32'(mon_stage), 32'(exp_ms()));
      check("kills", 32'(kills), 32'(m_kills));
      check("stage_clear", 32'(stage_clear), 32'(m_clr));
      check("game_won", 32'(game_won), 32'(m_won));
      check("game_over", 32'(game_over), 32'(m_over));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Random monster behaviour: spawned ones die then finish animation; unspawned ones are noise.
  task automatic rand_monsters(input bit allow_kill);
    for (int i = 0; i < 4; i++) begin
      if (i >= m_spawned) begin
        mon_dead[i] = ($urandom_range(0, 3) == 0);
        mon_state[4*i +: 4] = 4'($urandom_range(0, 15));
      end else if (!mon_dead[i]) begin
        if (allow_kill && $urandom_range(0, 15) == 0) mon_dead[i] = 1'b1;
        if (mon_state[4*i +: 4] == 4'hf) mon_state[4*i +: 4] = 4'h1;
      end else if ($urandom_range(0, 7) == 0) begin
        mon_state[4*i +: 4] = 4'hf;
      end
    end
  endtask

  task automatic run_until(input int phase, input int budget, input string tag);
    int n = 0;
    while (m_phase != phase && n < budget) begin
      rand_monsters(1'b1);
      tick();
      n++;
    end
    check(tag, 32'(m_phase), 32'(phase));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; player_dead = 1'b0; mon_dead = 4'd0; mon_state = 16'h1111;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_mon_stage", 32'(mon_stage), 32'h0000ffff);
    check("rst_kills", 32'(kills), 32'd0);

    // Start, then staggered spawn of two monsters for stage 1.
    start = 1'b1; tick(); start = 1'b0;
    check("start_stage", 32'(stage), 32'd1);
    check("start_ms0", 32'(mon_stage), 32'h0000ffff);
    tick();
    check("spawn0", 32'(mon_stage), 32'h0000fff1);
    repeat (3) tick();
    check("spawn1_early", 32'(mon_stage), 32'h0000fff1);
    tick();
    check("spawn1", 32'(mon_stage), 32'h0000ff11);
    check("fight1", 32'(m_phase), 32'(P_FIGHT));

    // Two simultaneous kills, then animation done -> clear.
    mon_dead = 4'b0011; tick();
    check("kills2", 32'(kills), 32'd2);
    mon_state = 16'h11ff; tick();
    check("clear_pulse", 32'(stage_clear), 32'd1);
    check("clear_ms", 32'(mon_stage), 32'h0000ffff);
    mon_dead = 4'd0; mon_state = 16'h1111;
    tick();
    check("clear_pulse_end", 32'(stage_clear), 32'd0);
    repeat (6) tick();
    check("hold_stage", 32'(stage), 32'd1);
    tick();
    check("next_stage", 32'(stage), 32'd2);
    repeat (9) tick();
    check("spawn3", 32'(mon_stage), 32'h0000f222);

    // Dead but animation still running -> no clear.
    mon_dead = 4'b0111;
    repeat (5) begin
      tick();
      check("no_clear", 32'(stage_clear), 32'd0);
    end
    mon_state = 16'h1fff; tick();
    check("late_clear", 32'(stage_clear), 32'd1);
    check("kills5", 32'(kills), 32'd5);
    mon_dead = 4'd0; mon_state = 16'h1111;

    // Finish stage 3 by random play without player death -> WIN.
    run_until(P_WIN, 3000, "reach_win");
    check("won", 32'(game_won), 32'd1);
    check("won_stage", 32'(stage), 32'hf);
    start = 1'b1; tick(); start = 1'b0;
    check("idle_stage", 32'(stage), 32'd0);
    check("idle_won", 32'(game_won), 32'd0);

    // Player death in the same cycle as the clear condition.
    mon_dead = 4'd0; mon_state = 16'h1111;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check("fight_again", 32'(m_phase), 32'(P_FIGHT));
    mon_dead = 4'b0011; mon_state = 16'h11ff; player_dead = 1'b1; tick();
    player_dead = 1'b0;
    check("lose_over", 32'(game_over), 32'd1);
    check("lose_no_clear", 32'(stage_clear), 32'd0);
    check("lose_ms", 32'(mon_stage), 32'h0000ffff);
    start = 1'b1; tick(); start = 1'b0;

    // Randomized play with occasional deaths, starts and resets.
    for (int c = 0; c < 4000; c++) begin
      rand_monsters(1'b1);
      player_dead = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; player_dead = 1'b0;

    // Kill saturation, then reset mid-fight.
    do_reset();
    mon_dead = 4'd0; mon_state = 16'h1111;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    for (int k = 0; k < 150; k++) begin
      mon_dead = 4'b0011; tick();
      mon_dead = 4'b0000; tick();
    end
    check("kills_sat", 32'(kills), 32'd255);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_stage", 32'(stage), 32'd0);
    check("midrst_kills", 32'(kills), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
